issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: dec_valid  in  1  decoded instruction present.
REQ-004 SHALL have ports: dec_ready  out  1  instruction accepted this cycle when high with dec_valid.
REQ-005 SHALL have ports: dec_inst  in  32  raw instruction word.
REQ-006 SHALL have ports: dec_in_reg_num  in  15  sources; [4:0]=src0, [9:5]=src1, [14:10]=src2.
REQ-007 SHALL have ports: dec_src_use  in  3  per-source read enable; dec_src_float  in  3  per-source 1=FPR, 0=GPR.
REQ-008 SHALL have ports: dec_out_reg_num  in  5; dec_out_general_reg  in  1; dec_out_float_reg  in  1  destination from decoder.
REQ-009 SHALL have ports: iss_valid  out  1; iss_ready  in  1; iss_inst  out  32; iss_out_reg_num  out  5; iss_out_general_reg  out  1; iss_out_float_reg  out  1.
REQ-010 SHALL have ports: wb_gen_en  in  1; wb_gen_reg  in  5; wb_fpr_en  in  1; wb_fpr_reg  in  5  writeback completions.
REQ-011 SHALL have ports: flush  in  1  discard issue slot; stall_count  out  16  saturating hazard-stall cycle count.

Function
REQ-012 SHALL keep 32 GPR busy bits and 32 FPR busy bits; GPR 0 SHALL never read as busy nor be set.
REQ-013 SHALL compute hazard = any source i with dec_src_use[i] whose busy bit (class per dec_src_float[i]) is set, OR destination (either class flag) busy (WAW).
REQ-014 SHALL drive dec_ready = (!iss_valid | iss_ready) & !hazard & !flush, combinationally.
REQ-015 SHALL on accept load the one-entry issue slot with dec_inst and destination fields, set iss_valid, and set the destination busy bit in the same edge (latency 1 cycle decode-to-issue).
REQ-016 SHALL clear iss_valid on iss_valid & iss_ready with no concurrent accept; busy bit stays set until writeback.
REQ-017 SHALL clear busy bit wb_gen_reg when wb_gen_en, wb_fpr_reg when wb_fpr_en; both ports may fire same cycle.
REQ-018 SHALL, when set and clear target the same bit in one cycle, let set win.
REQ-019 SHALL on flush clear iss_valid and clear the destination busy bit of the slot instruction (if iss_valid); other busy bits unchanged; accept blocked that cycle.
REQ-020 SHALL increment stall_count each cycle dec_valid & hazard & !flush, saturating at 0xFFFF.
REQ-021 SHALL treat an instruction with both destination flags low as having no destination (no WAW check, no busy set).

Reset
REQ-022 SHALL on rst_n low at a clk edge clear all busy bits, iss_valid=0, iss_inst=0, iss_out_reg_num=0, both iss flags=0, stall_count=0.
REQ-023 SHALL give reset priority over accept, writeback and flush; dec_ready SHALL be 0 while rst_n low.

Configuration
REQ-024 SHALL, with macro ISSUE_SCOREBOARD_WB_BYPASS_EN defined, exclude from the hazard check any busy bit being cleared by writeback in the same cycle (same-cycle accept).
REQ-025 SHALL, without ISSUE_SCOREBOARD_WB_BYPASS_EN, use registered busy bits only; dependant accepted one cycle after writeback.

Verification
REQ-026 SHALL test: reset, dec_valid with src0=3 GPR, dest GPR 5 -> accept, next cycle iss_valid=1, iss_out_reg_num=5, GPR5 busy.
REQ-027 SHALL test: dest GPR5 pending, next instr reads GPR5 -> dec_ready=0, stall_count increments 1 per cycle; wb_gen_en reg 5 -> accept same cycle (bypass) or next cycle (no bypass).
REQ-028 SHALL test: instr writes GPR0 then instr reads GPR0 -> no stall, no busy bit.
REQ-029 SHALL test: FPR 7 busy, source GPR 7 read -> no stall; source FPR 7 read -> stall.
REQ-030 SHALL test: iss_valid with dest FPR 2, iss_ready=0, flush=1 -> iss_valid=0, FPR2 not busy, dec_ready=0 that cycle.
REQ-031 SHALL test: 70000 hazard cycles -> stall_count holds 0xFFFF; rst_n low -> 0 next edge.

Source files
------------

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order issue stage. It tracks busy bits for 32 GPRs and
// 32 FPRs, holds decoded instructions back on RAW/WAW hazards, and keeps a
// one-entry issue slot.
// Optional feature: define ISSUE_SCOREBOARD_WB_BYPASS_EN to let a writeback
// release a dependant instruction in the same cycle.
module issue_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [31:0] dec_inst,
    input  logic [14:0] dec_in_reg_num,
    input  logic [2:0]  dec_src_use,
    input  logic [2:0]  dec_src_float,
    input  logic [4:0]  dec_out_reg_num,
    input  logic        dec_out_general_reg,
    input  logic        dec_out_float_reg,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [31:0] iss_inst,
    output logic [4:0]  iss_out_reg_num,
    output logic        iss_out_general_reg,
    output logic        iss_out_float_reg,
    input  logic        wb_gen_en,
    input  logic [4:0]  wb_gen_reg,
    input  logic        wb_fpr_en,
    input  logic [4:0]  wb_fpr_reg,
    input  logic        flush,
    output logic [15:0] stall_count
);

    logic [31:0] gpr_busy_q, gpr_busy_d;
    logic [31:0] fpr_busy_q, fpr_busy_d;
    logic        iss_valid_q, iss_valid_d;
    logic [31:0] iss_inst_q, iss_inst_d;
    logic [4:0]  iss_reg_q, iss_reg_d;
    logic        iss_gen_q, iss_gen_d;
    logic        iss_flt_q, iss_flt_d;
    logic [15:0] stall_q, stall_d;

    logic [31:0] wb_gpr_clr, wb_fpr_clr;
    logic [31:0] gpr_view, fpr_view;
    logic [4:0]  src;
    logic        hazard;
    logic        accept;

    // Writeback clear masks and the busy view used by the hazard check.
    always_comb begin
        wb_gpr_clr = wb_gen_en ? (32'd1 << wb_gen_reg) : 32'd0;
        wb_fpr_clr = wb_fpr_en ? (32'd1 << wb_fpr_reg) : 32'd0;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
        gpr_view = gpr_busy_q & ~wb_gpr_clr;
        fpr_view = fpr_busy_q & ~wb_fpr_clr;
`else
        gpr_view = gpr_busy_q;
        fpr_view = fpr_busy_q;
`endif
        // GPR 0 is hard-wired and never creates a dependency.
        gpr_view[0] = 1'b0;
    end

    // RAW check on enabled sources plus WAW check on the destination.
    always_comb begin
        hazard = 1'b0;
        src    = 5'd0;
        for (int i = 0; i < 3; i++) begin
            src = dec_in_reg_num[i*5 +: 5];
            if (dec_src_use[i]) begin
                if (dec_src_float[i] ? fpr_view[src] : gpr_view[src]) hazard = 1'b1;
            end
        end
        if (dec_out_general_reg && gpr_view[dec_out_reg_num]) hazard = 1'b1;
        if (dec_out_float_reg && fpr_view[dec_out_reg_num]) hazard = 1'b1;
        dec_ready = rst_n & (~iss_valid_q | iss_ready) & ~hazard & ~flush;
        accept    = dec_valid & dec_ready;
    end

    // Next-state for busy bits, issue slot and stall counter.
    always_comb begin
        gpr_busy_d  = gpr_busy_q & ~wb_gpr_clr;
        fpr_busy_d  = fpr_busy_q & ~wb_fpr_clr;
        iss_valid_d = iss_valid_q;
        iss_inst_d  = iss_inst_q;
        iss_reg_d   = iss_reg_q;
        iss_gen_d   = iss_gen_q;
        iss_flt_d   = iss_flt_q;
        stall_d     = stall_q;

        if (flush && iss_valid_q) begin
            if (iss_gen_q) gpr_busy_d[iss_reg_q] = 1'b0;
            if (iss_flt_q) fpr_busy_d[iss_reg_q] = 1'b0;
        end

        // Set is applied after the clears so it wins on a same-bit collision.
        if (accept) begin
            if (dec_out_general_reg) gpr_busy_d[dec_out_reg_num] = 1'b1;
            if (dec_out_float_reg)   fpr_busy_d[dec_out_reg_num] = 1'b1;
            iss_valid_d = 1'b1;
            iss_inst_d  = dec_inst;
            iss_reg_d   = dec_out_reg_num;
            iss_gen_d   = dec_out_general_reg;
            iss_flt_d   = dec_out_float_reg;
        end else if (flush) begin
            iss_valid_d = 1'b0;
        end else if (iss_valid_q && iss_ready) begin
            iss_valid_d = 1'b0;
        end
        gpr_busy_d[0] = 1'b0;

        if (dec_valid && hazard && !flush && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gpr_busy_q  <= '0;
            fpr_busy_q  <= '0;
            iss_valid_q <= 1'b0;
            iss_inst_q  <= '0;
            iss_reg_q   <= '0;
            iss_gen_q   <= 1'b0;
            iss_flt_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            gpr_busy_q  <= gpr_busy_d;
            fpr_busy_q  <= fpr_busy_d;
            iss_valid_q <= iss_valid_d;
            iss_inst_q  <= iss_inst_d;
            iss_reg_q   <= iss_reg_d;
            iss_gen_q   <= iss_gen_d;
            iss_flt_q   <= iss_flt_d;
            stall_q     <= stall_d;
        end
    end

    assign iss_valid           = iss_valid_q;
    assign iss_inst            = iss_inst_q;
    assign iss_out_reg_num     = iss_reg_q;
    assign iss_out_general_reg = iss_gen_q;
    assign iss_out_float_reg   = iss_flt_q;
    assign stall_count         = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with an expected-issue queue.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [14:0] dec_in_reg_num;
    logic [2:0]  dec_src_use;
    logic [2:0]  dec_src_float;
    logic [4:0]  dec_out_reg_num;
    logic        dec_out_general_reg;
    logic        dec_out_float_reg;
    logic        iss_valid;
    logic        iss_ready;
    logic [31:0] iss_inst;
    logic [4:0]  iss_out_reg_num;
    logic        iss_out_general_reg;
    logic        iss_out_float_reg;
    logic        wb_gen_en;
    logic [4:0]  wb_gen_reg;
    logic        wb_fpr_en;
    logic [4:0]  wb_fpr_reg;
    logic        flush;
    logic [15:0] stall_count;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        gen;
        logic        flt;
    } iss_t;

    iss_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;

    issue_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
        .dec_in_reg_num(dec_in_reg_num), .dec_src_use(dec_src_use),
        .dec_src_float(dec_src_float), .dec_out_reg_num(dec_out_reg_num),
        .dec_out_general_reg(dec_out_general_reg), .dec_out_float_reg(dec_out_float_reg),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst(iss_inst),
        .iss_out_reg_num(iss_out_reg_num), .iss_out_general_reg(iss_out_general_reg),
        .iss_out_float_reg(iss_out_float_reg),
        .wb_gen_en(wb_gen_en), .wb_gen_reg(wb_gen_reg),
        .wb_fpr_en(wb_fpr_en), .wb_fpr_reg(wb_fpr_reg),
        .flush(flush), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] inst,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] su, input logic [2:0] sf,
                       input logic [4:0] rd, input logic g, input logic f);
        dec_valid           = v;
        dec_inst            = inst;
        dec_in_reg_num      = {s2, s1, s0};
        dec_src_use         = su;
        dec_src_float       = sf;
        dec_out_reg_num     = rd;
        dec_out_general_reg = g;
        dec_out_float_reg   = f;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 5'd0, 1'b0, 1'b0);
    endtask

    // Expect the currently driven instruction to be accepted; queue its issue image.
    task automatic expect_accept(input string tag);
        chk(tag, {31'd0, dec_ready}, 32'd1);
        q.push_back('{dec_inst, dec_out_reg_num, dec_out_general_reg, dec_out_float_reg});
    endtask

    task automatic pop_issue(input string tag);
        iss_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty-queue expected=entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_valid"}, {31'd0, iss_valid}, 32'd1);
            chk({tag, "_inst"}, iss_inst, e.inst);
            chk({tag, "_rd"}, {27'd0, iss_out_reg_num}, {27'd0, e.rd});
            chk({tag, "_flags"}, {30'd0, iss_out_general_reg, iss_out_float_reg},
                {30'd0, e.gen, e.flt});
        end
    endtask

    initial begin
        rst_n = 1'b0; iss_ready = 1'b1; flush = 1'b0;
        wb_gen_en = 1'b0; wb_gen_reg = 5'd0; wb_fpr_en = 1'b0; wb_fpr_reg = 5'd0;
        drv(1'b1, 32'hDEAD0001, 5'd1, 5'd0, 5'd0, 3'b001, 3'b000, 5'd4, 1'b1, 1'b0);
        chk("rst_dec_ready", {31'd0, dec_ready}, 32'd0);
        tick(); tick();
        chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("rst_iss_inst", iss_inst, 32'd0);
        chk("rst_iss_rd", {27'd0, iss_out_reg_num}, 32'd0);
        chk("rst_flags", {30'd0, iss_out_general_reg, iss_out_float_reg}, 32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);

        // Basic accept: src0=GPR3, dest GPR5.
        idle();
        rst_n = 1'b1;
        drv(1'b1, 32'hA0000001, 5'd3, 5'd0, 5'd0, 3'b001, 3'b000, 5'd5, 1'b1, 1'b0);
        expect_accept("a_accept");
        tick();
        pop_issue("a_issue");

        // RAW on GPR5 stalls until writeback.
        drv(1'b1, 32'hB0000002, 5'd0, 5'd5, 5'd0, 3'b010, 3'b000, 5'd6, 1'b1, 1'b0);
        chk("b_raw_ready", {31'd0, dec_ready}, 32'd0);
        tick(); exp_stall++;
        chk("b_stall1", {16'd0, stall_count}, exp_stall);
        chk("a_drained", {31'd0, iss_valid}, 32'd0);
        tick(); exp_stall++;
        chk("b_stall2", {16'd0, stall_count}, exp_stall);
        wb_gen_en = 1'b1; wb_gen_reg = 5'd5; #1;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
        expect_accept("b_bypass_accept");
        tick();
        wb_gen_en = 1'b0;
        chk("b_stall_hold", {16'd0, stall_count}, exp_stall);
`else
        chk("b_wb_cycle_ready", {31'd0, dec_ready}, 32'd0);
        tick(); exp_stall++;
        wb_gen_en = 1'b0; #1;
        chk("b_stall3", {16'd0, stall_count}, exp_stall);
        expect_accept("b_after_wb_accept");
        tick();
`endif
        pop_issue("b_issue");
        idle();
        wb_gen_en = 1'b1; wb_gen_reg = 5'd6;
        tick();
        wb_gen_en = 1'b0;

        // GPR0 destination never becomes busy.
        drv(1'b1, 32'hC0000003, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 5'd0, 1'b1, 1'b0);
        expect_accept("c_accept");
        tick();
        pop_issue("c_issue");
        drv(1'b1, 32'hD0000004, 5'd0, 5'd0, 5'd0, 3'b001, 3'b000, 5'd0, 1'b0, 1'b0);
        expect_accept("d_gpr0_read");
        tick();
        pop_issue("d_issue");
        chk("d_stall_none", {16'd0, stall_count}, exp_stall);

        // FPR7 busy: GPR7 read passes, FPR7 read stalls.
        drv(1'b1, 32'hE0000005, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 5'd7, 1'b0, 1'b1);
        expect_accept("e_accept");
        tick();
        pop_issue("e_issue");
        drv(1'b1, 32'hF0000006, 5'd0, 5'd0, 5'd7, 3'b100, 3'b000, 5'd0, 1'b0, 1'b0);
        expect_accept("f_gpr7_read");
        tick();
        pop_issue("f_issue");
        drv(1'b1, 32'h10000007, 5'd0, 5'd0, 5'd7, 3'b100, 3'b100, 5'd0, 1'b0, 1'b0);
        chk("g_fpr7_ready", {31'd0, dec_ready}, 32'd0);
        tick(); exp_stall++;
        chk("g_stall", {16'd0, stall_count}, exp_stall);
        idle();
        wb_fpr_en = 1'b1; wb_fpr_reg = 5'd7;
        tick();
        wb_fpr_en = 1'b0;

        // Flush of a held slot with dest FPR2.
        iss_ready = 1'b0;
        drv(1'b1, 32'h20000008, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 5'd2, 1'b0, 1'b1);
        expect_accept("h_accept");
        tick();
        pop_issue("h_held");
        drv(1'b1, 32'h30000009, 5'd2, 5'd0, 5'd0, 3'b001, 3'b001, 5'd0, 1'b0, 1'b0);
        flush = 1'b1; #1;
        chk("flush_dec_ready", {31'd0, dec_ready}, 32'd0);
        tick();
        flush = 1'b0; #1;
        chk("flush_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("flush_no_stall", {16'd0, stall_count}, exp_stall);
        expect_accept("i_fpr2_free");
        tick();
        pop_issue("i_issue");
        iss_ready = 1'b1;

        // Same-cycle set and writeback on GPR9: set wins.
        drv(1'b1, 32'h4000000A, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 5'd9, 1'b1, 1'b0);
        wb_gen_en = 1'b1; wb_gen_reg = 5'd9; #1;
        expect_accept("j_accept");
        tick();
        wb_gen_en = 1'b0;
        pop_issue("j_issue");
        drv(1'b1, 32'h5000000B, 5'd9, 5'd0, 5'd0, 3'b001, 3'b000, 5'd0, 1'b0, 1'b0);
        chk("k_set_wins", {31'd0, dec_ready}, 32'd0);
        tick(); exp_stall++;
        idle();
        wb_gen_en = 1'b1; wb_gen_reg = 5'd9;
        tick();
        wb_gen_en = 1'b0;
        chk("k_stall", {16'd0, stall_count}, exp_stall);

        // Saturation: hold a hazard for 70000 cycles.
        drv(1'b1, 32'h6000000C, 5'd0, 5'd0, 5'd0, 3'b000, 3'b000, 5'd12, 1'b1, 1'b0);
        expect_accept("l_accept");
        tick();
        pop_issue("l_issue");
        drv(1'b1, 32'h7000000D, 5'd12, 5'd0, 5'd0, 3'b001, 3'b000, 5'd0, 1'b0, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall", {16'd0, stall_count}, 32'h0000FFFF);
        chk("sat_ready", {31'd0, dec_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("rst2_stall", {16'd0, stall_count}, 32'd0);
        chk("rst2_ready", {31'd0, dec_ready}, 32'd0);
        chk("rst2_iss_valid", {31'd0, iss_valid}, 32'd0);
        rst_n = 1'b1; #1;
        chk("rst2_busy_cleared", {31'd0, dec_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
